ray_t_div: RTL and testbench
============================

// Module: ray_t_div
// PURPOSE
//  Downstream consumer of two dot-product FIFO streams in the ray/plane intersection path.
//  - Pops a numerator dot(n, p0-o) and a denominator dot(n, d) together.
//  - Computes signed Q-format t = num/den with a multi-cycle restoring divider.
//  - Pushes t and a hit flag into the next stage's FIFO.
// PARAMETERS
//  Q_BITS  16             fractional bits of the fixed-point format (32-bit words)
//  T_MIN   32'h0000_0010  lower hit bound on t (Q16.16); used only with RAY_T_DIV_RANGE_EN
//  T_MAX   32'h7FFF_0000  upper hit bound on t (Q16.16); used only with RAY_T_DIV_RANGE_EN
// PORTS
//  clock      in   1   single clock for the whole block
//  reset      in   1   asynchronous, active-low reset
//  num        in   32  signed numerator, show-ahead FIFO data
//  num_empty  in   1   numerator FIFO empty
//  num_rd_en  out  1   numerator FIFO pop
//  den        in   32  signed denominator, show-ahead FIFO data
//  den_empty  in   1   denominator FIFO empty
//  den_rd_en  out  1   denominator FIFO pop
//  out_t      out  32  signed quotient t
//  out_hit    out  1   t is a valid forward hit
//  out_full   in   1   downstream FIFO full
//  out_wr_en  out  1   downstream FIFO push
// BEHAVIOUR
//  - Reset (reset==0): state=IDLE; out_t=0, out_hit=0, num_rd_en=den_rd_en=out_wr_en=0; count=0.
//  - FSM states IDLE -> DIV -> FIX -> WRITE -> IDLE.
//  - IDLE: when !num_empty && !den_empty, assert num_rd_en and den_rd_en together for one cycle.
//    Capture |num|<<Q_BITS as a 48-bit dividend, |den|, and sign = num[31]^den[31].
//    Never pop just one stream. If den==0, go straight to WRITE with out_t=32'h7FFF_FFFF and out_hit=0.
//  - DIV: one restoring-division step (one quotient bit) per cycle, 32+Q_BITS steps.
//    count runs 0..32+Q_BITS-1; the last step goes to FIX.
//  - FIX: if quotient magnitude > 2^31-1, saturate it to 2^31-1. Apply sign (two's complement).
//    Result truncates toward zero. Register the result into out_t, compute out_hit, go to WRITE.
//  - WRITE: out_wr_en=1 in any cycle where !out_full; go to IDLE in that same cycle.
//    While out_full=1, hold out_wr_en=0 with out_t/out_hit stable, and issue no pops.
//  - Latency: pop in cycle N; DIV covers N+1..N+48; FIX at N+49; earliest out_wr_en at N+50.
//    For den==0, earliest out_wr_en is at N+1.
//  - Throughput: one result per 50 cycles at most. No overlap between operations.
//  - out_t/out_hit change only in FIX or in the den==0 IDLE path, and hold otherwise.
//  - Reset asserted mid-DIV/FIX/WRITE aborts the operation: no push, and the popped pair is lost.
//  - Width rules:
//    - Dividend is 48 bits, remainder 33 bits; the divider runs unsigned on magnitudes.
//    - |-2^31| = 2^31 handled without overflow.
// CONFIGURATION
//  - RAY_T_DIV_RANGE_EN defined: out_hit = (den!=0) && (T_MIN < out_t) && (out_t < T_MAX),
//    compared signed; a saturated t gives hit=0.
//  - RAY_T_DIV_RANGE_EN undefined: out_hit = (den!=0) && (out_t > 0); T_MIN/T_MAX unused.
// STRUCTURE
//  - Shared package ray_pkg: typedef logic signed [31:0] fix_t; Q_BITS constant;
//    FIX_MAX=32'h7FFF_FFFF; FSM state enum type.
//  - Sub-module udiv_seq (unsigned restoring divider core).
//    Interface: start/dividend/divisor in; busy/done/quotient out.
//    ray_t_div owns the handshakes, sign, saturation and hit logic.
//  - Output FIFO is instantiated by the parent wrapper, not inside this block.
// TESTING
//  - num=32'h0002_0000 (2.0), den=32'h0000_8000 (0.5) -> out_t=32'h0004_0000, out_hit=1,
//    out_wr_en 50 cycles after the pop.
//  - num=32'hFFFD_0000 (-3.0), den=32'h0001_8000 (1.5) -> out_t=32'hFFFE_0000 (-2.0), out_hit=0.
//  - den=0, num=any -> out_t=32'h7FFF_FFFF, out_hit=0, out_wr_en exactly one cycle after the pop.
//  - num=32'h4000_0000, den=32'h0000_0001 -> saturates to out_t=32'h7FFF_FFFF.
//    out_hit=0 with RAY_T_DIV_RANGE_EN, out_hit=1 without it.
//  - num_empty=0, den_empty=1 for 20 cycles -> no rd_en asserted. Then den_empty=0 -> both rd_en pulse once.
//  - out_full=1 for 10 cycles in WRITE -> out_wr_en low, out_t stable, no pops; single push once out_full=0.
//    Reset low at DIV count=20 -> all outputs 0, no push, IDLE resumes cleanly.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types and constants for the ray/plane intersection t-divider.
// Fixed-point words are signed Q16.16 in 32 bits.
package ray_pkg;

  typedef logic signed [31:0] fix_t;

  // Fractional bits of the fixed-point format
  localparam int unsigned Q_BITS    = 16;
  // Dividend width (|num| << Q_BITS) and number of quotient bits produced
  localparam int unsigned DVD_W     = 32 + Q_BITS;
  localparam int unsigned DIV_STEPS = 32 + Q_BITS;
  // Largest positive fixed-point value, also the "no hit / infinite t" marker
  localparam fix_t        FIX_MAX   = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_FIX   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Unsigned magnitude of a signed word; |-2^31| = 2^31 fits in 32 unsigned bits
  function automatic logic [31:0] fix_abs(input fix_t v);
    logic [31:0] u;
    u = v;
    fix_abs = u[31] ? (~u + 32'd1) : u;
  endfunction

endpackage

// File: rtl/ray_t_div_if.sv
// Stream bundle for ray_t_div: two show-ahead input FIFOs (numerator,
// denominator) and one output FIFO write port.
// slave  = the divider block, master = whatever drives/consumes the FIFOs.
interface ray_t_div_if;
  import ray_pkg::*;

  fix_t num;
  logic num_empty;
  logic num_rd_en;
  fix_t den;
  logic den_empty;
  logic den_rd_en;
  fix_t out_t;
  logic out_hit;
  logic out_full;
  logic out_wr_en;

  modport slave (
    input  num, num_empty, den, den_empty, out_full,
    output num_rd_en, den_rd_en, out_t, out_hit, out_wr_en
  );

  modport master (
    output num, num_empty, den, den_empty, out_full,
    input  num_rd_en, den_rd_en, out_t, out_hit, out_wr_en
  );

endinterface

// File: rtl/ray_t_div_udiv_seq.sv
// udiv_seq: unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; DIVIDEND_W steps follow with busy_o high.
// done_o is high during the final step; quotient_o is valid from the next
// cycle on and holds until the next start.
module udiv_seq #(
  parameter int unsigned DIVIDEND_W = 48,
  parameter int unsigned DIVISOR_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o
);

  localparam int unsigned          CNT_W    = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  // dq holds the dividend being shifted out at the top and the quotient
  // being shifted in at the bottom.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  logic [DIVISOR_W+1:0]  rem_sh_s;
  logic [DIVISOR_W:0]    rem_sub_s;
  logic                  ge_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh_s  = {rem_q, dq_q[DIVIDEND_W-1]};
    ge_s      = (rem_sh_s >= {2'b00, dvs_q});
    rem_sub_s = rem_sh_s[DIVISOR_W:0] - {1'b0, dvs_q};

    dq_d   = dq_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    if (start_i) begin
      dq_d   = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      dq_d  = {dq_q[DIVIDEND_W-2:0], ge_s};
      rem_d = ge_s ? rem_sub_s : rem_sh_s[DIVISOR_W:0];
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dq_q   <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CNT_LAST);
  assign quotient_o = dq_q;

endmodule

// File: rtl/ray_t_div.sv
// ray_t_div: pops num = dot(n, p0-o) and den = dot(n, d) as a pair, computes
// signed Q16.16 t = num/den (truncated toward zero, magnitude saturated to
// 2^31-1) and pushes t with a hit flag to the next stage's FIFO.
// Optional build macro RAY_T_DIV_RANGE_EN: hit requires T_MIN < t < T_MAX
// instead of t > 0.
module ray_t_div
  import ray_pkg::*;
`ifdef RAY_T_DIV_RANGE_EN
#(
  parameter fix_t T_MIN = 32'sh0000_0010,
  parameter fix_t T_MAX = 32'sh7FFF_0000
)
`endif
(
  input  logic        clock,
  input  logic        reset,
  ray_t_div_if.slave  bus
);

  state_e             state_q, state_d;
  fix_t               out_t_q, out_t_d;
  logic               out_hit_q, out_hit_d;
  logic               sign_q, sign_d;
  // Keeps the pop path closed while in reset and for the first edge after it
  logic               armed_q;

  logic               pop_s;
  logic               rd_en_s;
  logic               wr_en_s;
  logic               div_start_s;
  logic               div_busy_s;
  logic               div_done_s;
  logic [DVD_W-1:0]   div_dividend_s;
  logic [31:0]        div_divisor_s;
  logic [DVD_W-1:0]   q_mag_s;
  logic [31:0]        sat_mag_s;
  fix_t               t_fix_s;
  logic               hit_fix_s;

  udiv_seq #(
    .DIVIDEND_W (DVD_W),
    .DIVISOR_W  (32)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .start_i    (div_start_s),
    .dividend_i (div_dividend_s),
    .divisor_i  (div_divisor_s),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (q_mag_s)
  );

  // Operand magnitudes, saturation, sign and hit for the finished quotient
  always_comb begin
    div_dividend_s = {fix_abs(bus.num), {Q_BITS{1'b0}}};
    div_divisor_s  = fix_abs(bus.den);
    pop_s          = armed_q && (state_q == ST_IDLE) && !bus.num_empty && !bus.den_empty;

    if (|q_mag_s[DVD_W-1:31]) begin
      sat_mag_s = 32'h7FFF_FFFF;
    end else begin
      sat_mag_s = {1'b0, q_mag_s[30:0]};
    end

    if (sign_q) begin
      t_fix_s = fix_t'(32'd0 - sat_mag_s);
    end else begin
      t_fix_s = fix_t'(sat_mag_s);
    end

`ifdef RAY_T_DIV_RANGE_EN
    hit_fix_s = (t_fix_s > T_MIN) && (t_fix_s < T_MAX);
`else
    hit_fix_s = (t_fix_s > 32'sd0);
`endif
  end

  // FSM next state, handshakes and result capture
  always_comb begin
    state_d     = state_q;
    out_t_d     = out_t_q;
    out_hit_d   = out_hit_q;
    sign_d      = sign_q;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;
    div_start_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          rd_en_s = 1'b1;
          sign_d  = bus.num[31] ^ bus.den[31];
          if (bus.den == 32'sd0) begin
            // Ray parallel to the plane: report "infinitely far, no hit"
            out_t_d   = FIX_MAX;
            out_hit_d = 1'b0;
            state_d   = ST_WRITE;
          end else begin
            div_start_s = 1'b1;
            state_d     = ST_DIV;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_d = ST_FIX;
        end else if (!div_busy_s) begin
          // Divider lost its operation; drop it rather than hang
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        out_t_d   = t_fix_s;
        out_hit_d = hit_fix_s;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (!bus.out_full) begin
          wr_en_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      out_t_q   <= 32'sd0;
      out_hit_q <= 1'b0;
      sign_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_t_q   <= out_t_d;
      out_hit_q <= out_hit_d;
      sign_q    <= sign_d;
      armed_q   <= 1'b1;
    end
  end

  assign bus.num_rd_en = rd_en_s;
  assign bus.den_rd_en = rd_en_s;
  assign bus.out_wr_en = wr_en_s;
  assign bus.out_t     = out_t_q;
  assign bus.out_hit   = out_hit_q;

endmodule

// File: tb/tb_ray_t_div.sv
// Self-checking bench for ray_t_div: queue-based FIFO models on both inputs,
// a plain-arithmetic reference for t/hit, directed corner cases and a
// randomized run with random FIFO stalls and output back-pressure.
`timescale 1ns/1ps
module tb_ray_t_div;
  import ray_pkg::*;

  localparam logic signed [31:0] TB_T_MIN = 32'sh0000_0010;
  localparam logic signed [31:0] TB_T_MAX = 32'sh7FFF_0000;

  typedef struct {
    logic [31:0] t;
    logic        hit;
    int          pop_cyc;
    int          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ray_t_div_if bus ();

  ray_t_div dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pops = 0;
  int          pushes = 0;
  bit          lat_chk = 1'b1;
  bit          hold_num = 1'b0;
  bit          hold_den = 1'b0;
  logic [31:0] nq[$];
  logic [31:0] dq[$];
  exp_t        expq[$];
  logic [31:0] t_log[$];
  logic        hit_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: t = num * 2^16 / den, truncated toward zero, |t| capped at 2^31-1
  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d, input int c);
    exp_t   e;
    longint sn, sd, q;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    e.pop_cyc = c;
    if (sd == 0) begin
      e.t   = 32'h7FFF_FFFF;
      e.hit = 1'b0;
      e.lat = 1;
    end else begin
      q = (sn * 64'sd65536) / sd;
      if (q > 64'sd2147483647)  q = 64'sd2147483647;
      if (q < -64'sd2147483647) q = -64'sd2147483647;
      e.t   = q[31:0];
`ifdef RAY_T_DIV_RANGE_EN
      e.hit = ($signed(e.t) > TB_T_MIN) && ($signed(e.t) < TB_T_MAX);
`else
      e.hit = ($signed(e.t) > 32'sd0);
`endif
      e.lat = 50;
    end
    return e;
  endfunction

  task automatic drive_fifos();
    bus.num       = (nq.size() > 0) ? nq[0] : 32'h0;
    bus.den       = (dq.size() > 0) ? dq[0] : 32'h0;
    bus.num_empty = (nq.size() == 0) || hold_num;
    bus.den_empty = (dq.size() == 0) || hold_den;
  endtask

  // One clock: monitor at negedge, retire popped FIFO entries after posedge
  task automatic tick();
    bit   popped;
    bit   avail;
    exp_t e;
    popped = 1'b0;
    @(negedge clock);
    cyc++;
    if (bus.num_rd_en || bus.den_rd_en) begin
      check_eq("pop_pair", 32'(bus.den_rd_en), 32'(bus.num_rd_en));
      avail = (nq.size() > 0) && (dq.size() > 0) && !bus.num_empty && !bus.den_empty;
      check_eq("pop_avail", 32'(avail), 32'd1);
      if (avail) begin
        expq.push_back(model(nq[0], dq[0], cyc));
        popped = 1'b1;
        pops++;
      end
    end
    if (bus.out_wr_en) begin
      pushes++;
      check_eq("wr_while_full", 32'(bus.out_full), 32'd0);
      check_eq("push_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check_eq("out_t", bus.out_t, e.t);
        check_eq("out_hit", 32'(bus.out_hit), 32'(e.hit));
        if (lat_chk) check_eq("latency", 32'(cyc - e.pop_cyc), 32'(e.lat));
        t_log.push_back(bus.out_t);
        hit_log.push_back(bus.out_hit);
      end
    end
    @(posedge clock);
    #1;
    if (popped) begin
      nq.delete(0);
      dq.delete(0);
    end
    drive_fifos();
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int n;
    n = 0;
    while ((pushes < target) && (n < budget)) begin
      tick();
      n++;
    end
    check_eq("push_timeout", 32'(pushes >= target), 32'd1);
  endtask

  initial begin
    int p0;
    int s0;
    int n;
    logic signed [31:0] rn;
    logic signed [31:0] rd;

    bus.out_full = 1'b0;
    // A pair is already waiting while reset is held: no pop may happen
    nq.push_back(32'h0002_0000); dq.push_back(32'h0000_8000);
    nq.push_back(32'hFFFD_0000); dq.push_back(32'h0001_8000);
    nq.push_back(32'h1234_5678); dq.push_back(32'h0000_0000);
    nq.push_back(32'h4000_0000); dq.push_back(32'h0000_0001);
    drive_fifos();
    repeat (3) @(negedge clock);
    check_eq("rst_out_t", bus.out_t, 32'h0);
    check_eq("rst_out_hit", 32'(bus.out_hit), 32'd0);
    check_eq("rst_num_rd", 32'(bus.num_rd_en), 32'd0);
    check_eq("rst_den_rd", 32'(bus.den_rd_en), 32'd0);
    check_eq("rst_wr", 32'(bus.out_wr_en), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Directed values with latency checks
    wait_pushes(4, 400);
    if (t_log.size() >= 4) begin
      check_eq("dir_2_div_0p5", t_log[0], 32'h0004_0000);
      check_eq("dir_2_hit", 32'(hit_log[0]), 32'd1);
      check_eq("dir_m3_div_1p5", t_log[1], 32'hFFFE_0000);
      check_eq("dir_m3_hit", 32'(hit_log[1]), 32'd0);
      check_eq("dir_den0", t_log[2], 32'h7FFF_FFFF);
      check_eq("dir_den0_hit", 32'(hit_log[2]), 32'd0);
      check_eq("dir_sat", t_log[3], 32'h7FFF_FFFF);
`ifdef RAY_T_DIV_RANGE_EN
      check_eq("dir_sat_hit", 32'(hit_log[3]), 32'd0);
`else
      check_eq("dir_sat_hit", 32'(hit_log[3]), 32'd1);
`endif
    end

    // Only the numerator FIFO has data: nothing may be popped
    p0 = pops;
    nq.push_back(32'h0003_0000);
    drive_fifos();
    repeat (20) tick();
    check_eq("one_sided_no_pop", 32'(pops), 32'(p0));
    dq.push_back(32'h0001_0000);
    drive_fifos();
    wait_pushes(pushes + 1, 100);
    check_eq("one_sided_single_pop", 32'(pops), 32'(p0 + 1));

    // Back-pressure in WRITE: hold result, no further pops, one push on release
    lat_chk = 1'b0;
    bus.out_full = 1'b1;
    p0 = pops;
    s0 = pushes;
    nq.push_back(32'hFFFF_0000); dq.push_back(32'hFFFE_0000);
    nq.push_back(32'h0000_4000); dq.push_back(32'h0002_0000);
    drive_fifos();
    repeat (52) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (expq.size() > 0) check_eq("full_hold_t", bus.out_t, expq[0].t);
    end
    check_eq("full_no_pop", 32'(pops), 32'(p0 + 1));
    check_eq("full_no_push", 32'(pushes), 32'(s0));
    bus.out_full = 1'b0;
    wait_pushes(s0 + 2, 200);
    lat_chk = 1'b1;

    // Reset during DIV at count 20 aborts the operation
    p0 = pops;
    nq.push_back(32'h0005_0000); dq.push_back(32'h0002_0000);
    nq.push_back(32'hFFF8_0000); dq.push_back(32'h0000_4000);
    drive_fifos();
    n = 0;
    while ((pops == p0) && (n < 10)) begin
      tick();
      n++;
    end
    check_eq("abort_pop_seen", 32'(pops), 32'(p0 + 1));
    repeat (20) tick();
    s0 = pushes;
    reset = 1'b0;
    #1;
    check_eq("abort_out_t", bus.out_t, 32'h0);
    check_eq("abort_out_hit", 32'(bus.out_hit), 32'd0);
    check_eq("abort_rd", 32'(bus.num_rd_en | bus.den_rd_en), 32'd0);
    check_eq("abort_wr", 32'(bus.out_wr_en), 32'd0);
    expq.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    wait_pushes(s0 + 1, 120);
    check_eq("abort_single_push", 32'(pushes), 32'(s0 + 1));

    // Randomized pairs with random FIFO stalls and back-pressure
    lat_chk = 1'b0;
    s0 = pushes;
    for (int i = 0; i < 30; i++) begin
      rn = $urandom;
      rd = $urandom;
      rn = rn >>> $urandom_range(0, 20);
      rd = rd >>> $urandom_range(0, 24);
      case ($urandom_range(0, 7))
        0: rd = 32'sd0;
        1: rn = 32'sh8000_0000;
        2: rd = 32'sh8000_0000;
        default: ;
      endcase
      nq.push_back(rn);
      dq.push_back(rd);
    end
    n = 0;
    while ((pushes < s0 + 30) && (n < 6000)) begin
      bus.out_full = ($urandom_range(0, 3) == 0);
      hold_num = ($urandom_range(0, 4) == 0);
      hold_den = ($urandom_range(0, 4) == 0);
      drive_fifos();
      tick();
      n++;
    end
    check_eq("rand_all_pushed", 32'(pushes), 32'(s0 + 30));
    bus.out_full = 1'b0;
    hold_num = 1'b0;
    hold_den = 1'b0;
    drive_fifos();
    repeat (5) tick();
    check_eq("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
